// File: rtl/jump_result_queue_pkg.sv
// Shared types and constants for the jump result path (jump_unit -> queue -> ROB).
package jump_result_queue_pkg;

    localparam int COMMON_WIDTH   = 32;
    localparam int INST_TAG_WIDTH = 4;

    // Tag value that jump_unit drives when it has no result this cycle.
    localparam logic [INST_TAG_WIDTH-1:0] TAG_INVALID_C = '1;

    typedef struct packed {
        logic [INST_TAG_WIDTH-1:0] tag;
        logic [COMMON_WIDTH-1:0]   next_pc;
        logic [COMMON_WIDTH-1:0]   ori_pc;
    } jump_result_t;

endpackage

// File: rtl/jump_result_queue_if.sv
// Bundle of the jump_unit capture port, ROB writeback port, fetch redirect and status.
interface jump_result_queue_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [TAG_W-1:0] in_target;
    logic [XLEN-1:0]  in_next_pc;
    logic [XLEN-1:0]  in_ori_pc;
    logic             flush;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [XLEN-1:0]  wb_val;
    logic             wb_ready;
    logic             redir_valid;
    logic [XLEN-1:0]  redir_pc;
    logic             afull;
    logic [CNT_W-1:0] count;
    logic             ovf_err;

    modport master (
        output in_target, in_next_pc, in_ori_pc, flush, wb_ready,
        input  wb_valid, wb_tag, wb_val, redir_valid, redir_pc, afull, count, ovf_err
    );

    modport slave (
        input  in_target, in_next_pc, in_ori_pc, flush, wb_ready,
        output wb_valid, wb_tag, wb_val, redir_valid, redir_pc, afull, count, ovf_err
    );

endinterface

// File: rtl/jump_result_queue_sync_fifo.sv
// Small in-order FIFO with synchronous flush. A push into a full FIFO is accepted
// only when a pop frees the head slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_nxt,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr_q];
    assign count   = cnt_q;
    assign count_nxt = cnt_d;

    // Next pointer/occupancy; flush wins over any push or pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are only meaningful below the occupancy, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/jump_result_queue.sv
// Buffers jump_unit results and drains them in order to the ROB writeback port,
// emitting a one-cycle fetch redirect per popped entry. Also provides back-pressure
// (afull) to dispatch since jump_unit cannot stall.
module jump_result_queue
    import jump_result_queue_pkg::*;
#(
    parameter int               DEPTH       = 4,
    parameter int               XLEN        = COMMON_WIDTH,
    parameter int               TAG_W       = INST_TAG_WIDTH,
    parameter logic [TAG_W-1:0] TAG_INVALID = {TAG_W{1'b1}},
    parameter int               AFULL_LVL   = DEPTH - 2
) (
    input logic               clk,
    input logic               rst,
    jump_result_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = TAG_W + 2 * XLEN;

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ENT_W-1:0] wdata;
    logic [ENT_W-1:0] rdata;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [TAG_W-1:0] head_tag;
    logic [XLEN-1:0]  head_next_pc;
    logic [XLEN-1:0]  head_ori_pc;
    logic             redir_valid_q;
    logic [XLEN-1:0]  redir_pc_q;
    logic             afull_q;
    logic             ovf_err_q;

    assign push  = (bus.in_target != TAG_INVALID);
    assign wdata = {bus.in_target, bus.in_next_pc, bus.in_ori_pc};
    assign {head_tag, head_next_pc, head_ori_pc} = rdata;

    // A flush cycle hides the head so the ROB cannot accept an entry being discarded.
    assign bus.wb_valid = !fifo_empty && !bus.flush;
    assign pop          = bus.wb_valid && bus.wb_ready;
    assign bus.wb_tag   = fifo_empty ? TAG_INVALID : head_tag;
    assign bus.wb_val   = fifo_empty ? '0 : head_ori_pc;

    assign bus.count       = cnt_q;
    assign bus.afull       = afull_q;
    assign bus.ovf_err     = ovf_err_q;
    assign bus.redir_valid = redir_valid_q;
    assign bus.redir_pc    = redir_pc_q;

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (bus.flush),
        .wdata     (wdata),
        .rdata     (rdata),
        .count     (cnt_q),
        .count_nxt (cnt_nxt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Redirect pulse follows each pop by one cycle; the target is held between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else if (pop) begin
            redir_valid_q <= 1'b1;
            redir_pc_q    <= head_next_pc;
        end else begin
            redir_valid_q <= 1'b0;
        end
    end

    // Almost-full is registered from the post-edge occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) afull_q <= 1'b0;
        else     afull_q <= (cnt_nxt >= CNT_W'(AFULL_LVL));
    end

    // Sticky overflow: a result was lost because the queue was full with no pop.
    // A flush discards the push anyway, so it is not counted as an overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_err_q <= 1'b0;
        else if (push && fifo_full && !pop && !bus.flush) ovf_err_q <= 1'b1;
    end

endmodule

// File: doc/jump_result_queue.md
Name: jump_result_queue

Overview:
Downstream of jump_unit. Captures each issued jump result (target tag, next_pc, ori_pc) and buffers it in a small in-order FIFO. Drains one entry per handshake onto the ROB writeback port: the link value is ori_pc, for rd. On the same pop it emits a single-cycle PC redirect to fetch. Also supplies an almost-full back-pressure flag to dispatch, because jump_unit itself cannot stall.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
XLEN, 32, data/PC width (matches COMMON_WIDTH)
TAG_W, 4, instruction tag width (matches INST_TAG_WIDTH)
TAG_INVALID, {TAG_W{1'b1}}, tag value meaning "no result"
AFULL_LVL, DEPTH-2, occupancy at or above which afull asserts

Ports:
clk  in  1  clock; sampled on posedge (jump_unit drives on negedge)
rst  in  1  reset, asynchronous, active-high
in_target  in  TAG_W  result tag from jump_unit; TAG_INVALID = no push
in_next_pc  in  XLEN  computed jump destination
in_ori_pc  in  XLEN  pc+4 link value
flush  in  1  mispredict/exception flush from ROB; synchronous
wb_valid  out  1  ROB writeback request
wb_tag  out  TAG_W  tag being written back
wb_val  out  XLEN  link value (ori_pc of head)
wb_ready  in  1  ROB accepts writeback this cycle
redir_valid  out  1  one-cycle redirect pulse to fetch
redir_pc  out  XLEN  redirect target (next_pc of popped entry)
afull  out  1  occupancy >= AFULL_LVL; dispatch must stop sending jumps
count  out  $clog2(DEPTH)+1  current occupancy
ovf_err  out  1  sticky: push attempted while full and not popping

Behaviour:
- Reset (async, rst=1): occupancy 0, rd/wr pointers 0, wb_valid=0, wb_tag=TAG_INVALID, wb_val=0, redir_valid=0, redir_pc=0, afull=0, count=0, ovf_err=0. Reset mid-operation discards all entries and takes effect immediately.
- Push: at posedge, if in_target != TAG_INVALID, write {tag,next_pc,ori_pc} at wr_ptr. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Head presentation: wb_valid = (count != 0) && !flush. wb_tag and wb_val are driven combinationally from the head entry. When empty, wb_tag=TAG_INVALID.
- Pop: at posedge, if wb_valid && wb_ready, advance rd_ptr. redir_valid is registered to 1 on the next cycle only, and redir_pc takes the popped next_pc. Otherwise redir_valid is 0 and redir_pc holds its value.
- Latency: a push at edge N is visible on wb_* after edge N. The earliest pop is at edge N+1, with redir_valid high during cycle N+1..N+2.
- Simultaneous push+pop: count is unchanged, and this is legal even when full (the push slot is freed in the same edge).
- Full, push without pop: the entry is dropped, ovf_err is set to 1 until rst, and count stays at DEPTH.
- Empty with wb_ready=1: no effect.
- flush=1 at posedge: count=0, pointers=0, and any same-cycle push is discarded. No pop or redirect happens that edge, and redir_valid is 0 next cycle. ovf_err is kept.
- afull and count are registered and track post-edge occupancy.
- Order is strictly FIFO; the ROB tag order is not reordered.

Decomposition:
- Shared package (common pkg): struct jump_result_t {tag, next_pc, ori_pc}, plus the TAG_INVALID constant shared with jump_unit and the ROB.
- One natural sub-module, sync_fifo (parameterised width/depth, push/pop/flush, count, full/empty). jump_result_queue wraps it with the handshake, redirect register, afull and ovf_err logic.

Test Plan:
- Single jump: push tag=3, next_pc=0x100, ori_pc=0x24, wb_ready=1. Expect wb_valid/wb_tag=3/wb_val=0x24 the cycle after the push. After the pop, expect redir_valid=1 for exactly one cycle with redir_pc=0x100, then count=0.
- Back-pressure: wb_ready=0, push tags 1,2,3. Expect count=3 and afull=1 (DEPTH=4). Then wb_ready=1: pops come out in order 1,2,3 with redirects 1 cycle after each.
- Full + simultaneous push/pop: fill 4 entries, then push tag 5 with wb_ready=1. Expect count stays 4, ovf_err=0, and tag 5 emerges last. A push while full with wb_ready=0 sets ovf_err=1 and drops the entry.
- Wrap-around: 10 push/pop pairs, back-to-back. Expect tags and PCs match in order across pointer wrap, and count never exceeds 1.
- Flush: 3 entries queued, then flush=1 together with a push of tag 7. Expect count=0, wb_valid=0 and no redir_valid next cycle; tag 7 never appears.
- Async reset mid-drain: assert rst between clock edges while count=2. Expect all outputs at reset values immediately. After release, a new push behaves as the single-jump case.
